// File: rtl/tuning_code_engine.sv
// MIDI note to NCO tuning-code engine with per-voice portamento.
// Notes are octave-normalised into a top-octave table, then shifted down.
module tuning_code_engine #(
    parameter int VOICES      = 4,
    parameter int CODE_W      = 32,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [3:0]               note_voice,
    input  logic [6:0]               note_num,
    input  logic                     glide_en,
    input  logic                     tick,
    output logic                     upd_valid,
    output logic [3:0]               upd_voice,
    output logic [VOICES*CODE_W-1:0] code_out
);

    typedef enum logic [1:0] {IDLE, NORM, LOAD} state_t;

    localparam logic [CODE_W:0] THRESH = (CODE_W+1)'(1) << GLIDE_SHIFT;

    state_t state, state_nx;

    logic [7:0]  n;
    logic [3:0]  sh;
    logic [3:0]  voice;
    logic        voice_ok;
    logic [20:0] top;
    logic [CODE_W-1:0] load_val;

    logic [VOICES-1:0][CODE_W-1:0] tgt;
    logic [VOICES-1:0][CODE_W-1:0] cur;
    logic [VOICES-1:0][CODE_W-1:0] glide_nx;
    logic signed [CODE_W:0] d   [VOICES];
    logic signed [CODE_W:0] mag [VOICES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (note_valid) state_nx = NORM;
            NORM:    if (n >= 8'd120) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        note_ready = (state == IDLE);
    end

    assign voice_ok = {1'b0, voice} < 5'(VOICES);

    // Raise the note by octaves until it lands in the table octave,
    // counting how many halvings the table entry then needs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n     <= '0;
            sh    <= '0;
            voice <= '0;
        end else if (state == IDLE && note_valid) begin
            n     <= {1'b0, note_num};
            sh    <= '0;
            voice <= note_voice;
        end else if (state == NORM && n < 8'd120) begin
            n     <= n + 8'd12;
            sh    <= sh + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            upd_valid <= 1'b0;
            upd_voice <= '0;
        end else begin
            upd_valid <= (state == LOAD) && voice_ok;
            if (state == LOAD && voice_ok) upd_voice <= voice;
        end
    end

    always_comb begin
        case (n)
            8'd120:  top = 21'd749115;
            8'd121:  top = 21'd793660;
            8'd122:  top = 21'd840853;
            8'd123:  top = 21'd890853;
            8'd124:  top = 21'd943826;
            8'd125:  top = 21'd999948;
            8'd126:  top = 21'd1059409;
            8'd127:  top = 21'd1122404;
            8'd128:  top = 21'd1189146;
            8'd129:  top = 21'd1259856;
            8'd130:  top = 21'd1334770;
            8'd131:  top = 21'd1414140;
            default: top = 21'd0;
        endcase
        load_val = CODE_W'(top) >> sh;
    end

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            d[v]   = $signed({1'b0, tgt[v]}) - $signed({1'b0, cur[v]});
            mag[v] = d[v][CODE_W] ? -d[v] : d[v];
            if ($unsigned(mag[v]) < THRESH) glide_nx[v] = tgt[v];
            else glide_nx[v] = cur[v] + CODE_W'(d[v] >>> GLIDE_SHIFT);
        end
    end

    // A coincident tick glides toward the old target unless the load jumps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tgt <= '0;
            cur <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (state == LOAD && voice == 4'(v)) begin
                    tgt[v] <= load_val;
                    if (!glide_en) cur[v] <= load_val;
                    else if (tick) cur[v] <= glide_nx[v];
                end else if (tick) begin
                    cur[v] <= glide_en ? glide_nx[v] : tgt[v];
                end
            end
        end
    end

    assign code_out = cur;

endmodule
